// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures the high time of an RC servo pulse, recovers the
// N-bit position code, flags short/long pulses and loss of signal.
//
//   state     | meaning
//   S_WAITLOW | wait for input low before arming (no partial pulses)
//   S_IDLE    | armed, waiting for a rising edge
//   S_BASE    | timing the fixed 1 ms base of the pulse
//   S_STEP    | counting position steps until the pulse falls
`timescale 1ns/1ps
module servo_pulse_decoder #(
  parameter int CLK_PER_NS = 40,
  parameter int N          = 8,
  parameter int TIMEOUT_MS = 25
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         pwm_i,
  output logic [N-1:0] position_o,
  output logic         valid_o,
  output logic         err_o,
  output logic         lost_o
);

  localparam int MS_CYC   = 1_000_000 / CLK_PER_NS + 1;
  localparam int STEP_CYC = (1_000_000 / CLK_PER_NS) / (2**N) + 1;
  localparam int TICK_W   = $clog2(MS_CYC);
  localparam int SUB_W    = $clog2(STEP_CYC + 1);
  localparam int STEP_W   = N + 1;
  localparam int LOST_W   = $clog2(TIMEOUT_MS + 1);

  localparam logic [TICK_W-1:0] MS_LAST   = TICK_W'(MS_CYC - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(STEP_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2**N - 1);
  localparam logic [LOST_W-1:0] LOST_MAX  = LOST_W'(TIMEOUT_MS);

  typedef enum logic [1:0] {S_WAITLOW, S_IDLE, S_BASE, S_STEP} state_t;

  state_t              r_state;
  logic                r_pwm_meta;
  logic                r_pwm_s;
  logic                r_pwm_d;
  logic [TICK_W-1:0]   r_base_cnt;
  logic [SUB_W-1:0]    r_sub_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [LOST_W-1:0]   r_lost_cnt;
  logic [N-1:0]        r_position;
  logic                r_valid;
  logic                r_err;
  logic                r_lost;
  logic                w_rise;
  logic                w_tick;

  assign w_rise = r_pwm_s & ~r_pwm_d;
  assign w_tick = (r_tick_cnt == MS_LAST);

  // Chain resets high so a pulse already in progress at reset release is never
  // seen as a fresh rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pwm_meta <= 1'b1;
      r_pwm_s    <= 1'b1;
      r_pwm_d    <= 1'b1;
    end else begin
      r_pwm_meta <= pwm_i;
      r_pwm_s    <= r_pwm_meta;
      r_pwm_d    <= r_pwm_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tick_cnt <= '0;
      r_lost_cnt <= '0;
    end else if (!en_i) begin
      r_tick_cnt <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_rise)
        r_lost_cnt <= '0;
      else if (w_tick && (r_lost_cnt != LOST_MAX))
        r_lost_cnt <= r_lost_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_WAITLOW;
      r_base_cnt <= '0;
      r_sub_cnt  <= '0;
      r_step_cnt <= '0;
      r_position <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_lost     <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_lost_cnt == LOST_MAX)
        r_lost <= 1'b1;
      if (!en_i) begin
        r_state    <= S_WAITLOW;
        r_base_cnt <= '0;
        r_sub_cnt  <= '0;
        r_step_cnt <= '0;
      end else begin
        case (r_state)
          S_WAITLOW: begin
            if (!r_pwm_s)
              r_state <= S_IDLE;
          end
          S_IDLE: begin
            if (w_rise) begin
              r_base_cnt <= '0;
              r_state    <= S_BASE;
            end
          end
          S_BASE: begin
            if (!r_pwm_s) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_base_cnt == MS_LAST) begin
              r_sub_cnt  <= '0;
              r_step_cnt <= '0;
              r_state    <= S_STEP;
            end else begin
              r_base_cnt <= r_base_cnt + 1'b1;
            end
          end
          S_STEP: begin
            if (!r_pwm_s) begin
              r_position <= r_step_cnt[N-1:0];
              r_valid    <= 1'b1;
              r_lost     <= 1'b0;
              r_state    <= S_IDLE;
            end else if (r_sub_cnt == SUB_LAST) begin
              r_sub_cnt  <= '0;
              r_step_cnt <= r_step_cnt + 1'b1;
              // Step count about to reach 2**N with the pulse still high: too long.
              if (r_step_cnt == STEP_LAST) begin
                r_err   <= 1'b1;
                r_state <= S_WAITLOW;
              end
            end else begin
              r_sub_cnt <= r_sub_cnt + 1'b1;
            end
          end
          default: r_state <= S_WAITLOW;
        endcase
      end
    end
  end

  assign position_o = r_position;
  assign valid_o    = r_valid;
  assign err_o      = r_err;
  assign lost_o     = r_lost;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Randomized bench for servo_pulse_decoder; scaled-down timing constants keep
// the run short while exercising the same pulse-width rules.
`timescale 1ns/1ps
module tb_servo_pulse_decoder;

  localparam int CLK_PER_NS = 2000;
  localparam int N          = 5;
  localparam int TIMEOUT_MS = 4;
  localparam int MS         = 1_000_000 / CLK_PER_NS + 1;
  localparam int STEP       = (1_000_000 / CLK_PER_NS) / (2**N) + 1;
  localparam int LIMIT      = MS + (2**N) * STEP;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         pwm_i;
  logic [N-1:0] position_o;
  logic         valid_o;
  logic         err_o;
  logic         lost_o;

  servo_pulse_decoder #(
    .CLK_PER_NS(CLK_PER_NS),
    .N(N),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) u_dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .pwm_i(pwm_i),
    .position_o(position_o),
    .valid_o(valid_o),
    .err_o(err_o),
    .lost_o(lost_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct {
    bit          is_err;
    int unsigned cyc;
    int unsigned pos;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_rise = 0;
  int unsigned model_pos = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outcome comes from the pulse-width rules alone: too short, decoded
  // position (residual rounds down), or too long (error once 2**N steps elapse).
  task automatic pulse(input int h, input int gap);
    exp_t e;
    @(negedge clk_i);
    pwm_i = 1'b1;
    last_rise = cyc;
    if (h <= MS) begin
      e.is_err = 1'b1; e.cyc = cyc + h + 3; e.pos = 0;
    end else if (h <= LIMIT) begin
      e.is_err = 1'b0; e.cyc = cyc + h + 3; e.pos = (h - MS - 1) / STEP;
    end else begin
      e.is_err = 1'b1; e.cyc = cyc + LIMIT + 3; e.pos = 0;
    end
    exp_q.push_back(e);
    repeat (h) @(negedge clk_i);
    pwm_i = 1'b0;
    repeat (gap) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && (valid_o || err_o)) begin
      chk("no_dual_strobe", valid_o & err_o, 0);
      chk("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind_err", err_o, mon_e.is_err);
        chk("strobe_cycle", cyc, mon_e.cyc);
        if (valid_o) begin
          chk("position", position_o, mon_e.pos);
          chk("lost_clr_on_valid", lost_o, 0);
          model_pos = mon_e.pos;
        end else begin
          chk("position_hold_on_err", position_o, model_pos);
        end
      end
    end
  end

  initial begin
    int h;
    int sel;
    rst_i = 1'b1;
    en_i  = 1'b1;
    pwm_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_position", position_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_lost", lost_o, 1);

    // pulse already high when reset releases: must be ignored
    rst_i = 1'b0;
    repeat (300) @(negedge clk_i);
    pwm_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("startup_position", position_o, 0);
    chk("startup_lost", lost_o, 1);

    pulse(MS + STEP*10 + 1, 40);
    chk("p10_position", position_o, 10);
    chk("p10_lost", lost_o, 0);
    pulse(MS + 1, 40);
    chk("p0_position", position_o, 0);
    pulse(MS + STEP*(2**N - 1) + 1, 40);
    chk("pmax_position", position_o, 2**N - 1);
    pulse(LIMIT, 40);
    pulse(MS + STEP*10 + 1, 40);
    pulse(MS, 40);
    pulse(400, 40);
    chk("short_keeps_position", position_o, 10);
    pulse(LIMIT + 1, 40);
    pulse(LIMIT + 300, 40);
    chk("long_keeps_position", position_o, 10);
    pulse(MS + STEP*8, 40);
    chk("residual_rounds_down", position_o, 7);

    // enable dropped mid-pulse, then a whole pulse while disabled
    @(negedge clk_i);
    pwm_i = 1'b1;
    repeat (200) @(negedge clk_i);
    en_i = 1'b0;
    repeat (20) @(negedge clk_i);
    en_i = 1'b1;
    repeat (300) @(negedge clk_i);
    pwm_i = 1'b0;
    repeat (20) @(negedge clk_i);
    en_i = 1'b0;
    pwm_i = 1'b1;
    repeat (600) @(negedge clk_i);
    pwm_i = 1'b0;
    repeat (20) @(negedge clk_i);
    en_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("en_hold_position", position_o, 7);
    chk("en_hold_lost", lost_o, 0);
    pulse(MS + STEP*3 + 1, 40);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2)       h = $urandom_range(1, MS);
      else if (sel == 2) h = $urandom_range(LIMIT + 1, LIMIT + 200);
      else               h = $urandom_range(MS + 1, LIMIT);
      pulse(h, $urandom_range(5, 150));
    end

    // loss of signal, then recovery
    pulse(MS + STEP*5 + 1, 20);
    repeat (int'(last_rise) + 3*MS - 5 - int'(cyc)) @(negedge clk_i);
    chk("lost_not_yet", lost_o, 0);
    repeat (int'(last_rise) + TIMEOUT_MS*MS + 10 - int'(cyc)) @(negedge clk_i);
    chk("lost_set", lost_o, 1);
    pulse(100, 40);
    chk("lost_kept_after_err", lost_o, 1);
    pulse(MS + STEP*20 + 1, 40);
    chk("lost_cleared", lost_o, 0);
    chk("final_position", position_o, 20);

    repeat (20) @(negedge clk_i);
    chk("pending_strobes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
